uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver directly downstream of the baud-rate tick generator.
- Consumes the 16x-oversampling `tick` strobe and samples the serial `rx` line.
- Recovers 8N1-style frames, LSB first.
- Presents each received byte with a one-clock `rx_done` pulse and a framing-error flag for the next stage (interface/FIFO).

Parameters:
N_BITS, 8, number of data bits per frame
SB_TICK, 16, ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
OVERSAMPLE, 16, ticks per bit period; must be even and >= 4

Ports:
clock  input  1  system clock
reset  input  1  synchronous reset, active-low (block is reset when reset == 0)
tick  input  1  oversampling strobe, one clock wide, OVERSAMPLE per bit period
rx  input  1  asynchronous serial input, idle high
dout  output  N_BITS  last received data word
rx_done  output  1  one-clock pulse, dout valid
frame_error  output  1  stop bit sampled low on last frame
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- rx path:
  - rx passes through a 2-flop synchronizer; both flops reset to 1.
  - All "rx" references below mean the synchronized value, which lags the pin by 2 clocks.
- Reset (reset == 0 at a clock edge):
  - state = IDLE; tick counter s = 0; bit counter n = 0; shift register b = 0.
  - dout = 0, rx_done = 0, frame_error = 0, busy = 0.
  - Reset mid-frame discards the partial frame with no rx_done pulse.
- Counters:
  - s is clog2(max(OVERSAMPLE, SB_TICK)) bits wide.
  - n is clog2(N_BITS) bits wide.
  - Neither counter ever wraps: each is explicitly cleared on every state transition.
- States: IDLE, START, DATA, STOP.
- IDLE: when rx == 0 (regardless of tick), go to START with s = 0.
- START: on tick:
  - If s == OVERSAMPLE/2-1 and rx == 0: go to DATA with s = 0, n = 0.
  - If s == OVERSAMPLE/2-1 and rx == 1: false start; return to IDLE, no pulse, outputs unchanged.
  - Otherwise s = s+1.
- DATA: on tick:
  - If s == OVERSAMPLE-1: s = 0 and b = {rx, b[N_BITS-1:1]} (LSB first).
    - If n == N_BITS-1, go to STOP; otherwise n = n+1.
  - Otherwise s = s+1.
- STOP: on tick:
  - If s == SB_TICK-1: go to IDLE and, in the same edge, set dout = b, frame_error = ~rx, rx_done = 1.
  - Otherwise s = s+1.
- Tick gating:
  - Without tick, START, DATA and STOP hold all state.
  - Only the IDLE exit ignores tick.
- Output timing:
  - rx_done is registered and high exactly one clock; it drops the next clock unconditionally.
  - dout and frame_error hold until the next completed frame or reset.
  - frame_error is updated on every frame completion, including clearing it.
  - The frame is still delivered when frame_error = 1.
- Back-to-back frames:
  - A start edge arriving in the clock immediately after the STOP-to-IDLE transition is accepted.
  - There is no dead time beyond the one IDLE clock.
- rx glitches during DATA/STOP are ignored except at the sample points.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Drive tick every 16 clocks, send 0xA5 with 1 stop bit -> exactly one rx_done pulse; dout = 0xA5, frame_error = 0, busy high for the whole frame, low after.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_done pulses; dout = 0x00 then 0xFF; no bit slip.
- rx low for 4 ticks then high (glitch) -> START aborts to IDLE; no rx_done; dout keeps its previous value.
- Send 0x3C with the stop bit driven low -> rx_done pulse; dout = 0x3C, frame_error = 1. Then a valid 0x12 -> frame_error = 0.
- Assert reset (0) during bit 4 of a frame, release, send 0x81 -> no pulse for the aborted frame; next dout = 0x81; all outputs 0 during reset.
- SB_TICK = 32 and N_BITS = 7, send 0x55 -> rx_done occurs 32 ticks after the last data sample; dout = 7'h55.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the line/tick sources and the byte consumer.
// The receiver takes the slave view; whoever drives tick and rx takes master.
interface uart_rx_if #(
    parameter int N_BITS = 8
);
    logic              tick;
    logic              rx;
    logic [N_BITS-1:0] dout;
    logic              rx_done;
    logic              frame_error;
    logic              busy;

    modport master (
        output tick,
        output rx,
        input  dout,
        input  rx_done,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  tick,
        input  rx,
        output dout,
        output rx_done,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: recovers LSB-first frames from a synchronized rx line
// and hands each word over with a one-clock rx_done pulse and a framing-error flag.
module uart_rx #(
    parameter int N_BITS     = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clock,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(N_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [S_W-1:0]    s_reg, s_next;
    logic [N_W-1:0]    n_reg, n_next;
    logic [N_BITS-1:0] b_reg, b_next;
    logic [N_BITS-1:0] dout_reg, dout_next;
    logic              fe_reg, fe_next;
    logic              done_reg, done_next;
    logic              busy_reg, busy_next;
    logic [1:0]        rx_sync_reg;
    logic              rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_sync_reg <= 2'b11;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], bus.rx};
        end
    end

    assign rx_s = rx_sync_reg[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            fe_reg    <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            fe_reg    <= fe_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        fe_next    = fe_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (bus.tick) begin
                    // Half a bit in: a line back at 1 was only a glitch.
                    if (s_reg == S_HALF) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = rx_s ? IDLE : DATA;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[N_BITS-1:1]};
                        if (n_reg == N_LAST) begin
                            n_next     = '0;
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (bus.tick) begin
                    if (s_reg == S_STOP) begin
                        s_next     = '0;
                        state_next = IDLE;
                        dout_next  = b_reg;
                        fe_next    = ~rx_s;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                s_next     = '0;
                n_next     = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.dout        = dout_reg;
    assign bus.rx_done     = done_reg;
    assign bus.frame_error = fe_reg;
    assign bus.busy        = busy_reg;
endmodule
